// File: rtl/autosym_check_pkg.sv
// Shared types for the autosymmetry equivalence-check readers: sweep FSM states
// and truth-table sizing.
package autosym_check_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DRAIN,
        DONE
    } state_e;

    localparam int N_IN_DEF = 6;

    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/tt_index_pipe.sv
// Delay line carrying (valid, index) LAT cycles behind the driven vector so each
// netlist response is written to the bit it belongs to; flush drops in-flight entries.
module tt_index_pipe #(
    parameter int LAT = 0,
    parameter int IW  = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_vld,
    input  logic [IW-1:0] in_idx,
    output logic          out_vld,
    output logic [IW-1:0] out_idx
);

    if (LAT == 0) begin : g_wire
        logic unused_pipe;
        assign unused_pipe = clk ^ rst_n ^ flush;
        assign out_vld     = in_vld;
        assign out_idx     = in_idx;
    end else begin : g_pipe
        logic [LAT-1:0]         vld_q, vld_d;
        logic [LAT-1:0][IW-1:0] idx_q, idx_d;

        // Shifts are written as whole-vector shifts so LAT = 1 needs no special case.
        always_comb begin
            vld_d = flush ? '0 : ((vld_q << 1) | LAT'(in_vld));
            idx_d = (idx_q << IW) | (LAT*IW)'(in_idx);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                idx_q <= '0;
            end else begin
                vld_q <= vld_d;
                idx_q <= idx_d;
            end
        end

        assign out_vld = vld_q[LAT-1];
        assign out_idx = idx_q[LAT-1];
    end

endmodule

// File: rtl/tt_capture_checker.sv
// Sweeps all input vectors of a single-output netlist, captures its truth table
// and compares it against the expected table from the original PLA.
module tt_capture_checker
    import autosym_check_pkg::*;
#(
    parameter  int N_IN    = N_IN_DEF,
    parameter  int DUT_LAT = 0,
    localparam int TT_W    = tt_width(N_IN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] expected,
    input  logic            dut_y,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            match,
    output logic [TT_W-1:0] tt_out,
    output logic [N_IN:0]   mismatch_cnt,
    output logic [N_IN-1:0] first_mismatch
);

    localparam int              DW         = $clog2(DUT_LAT + 2);
    localparam logic [N_IN-1:0] VEC_MAX    = '1;
    localparam logic [N_IN:0]   CNT_SAT    = (N_IN+1)'(TT_W);
    localparam logic [DW-1:0]   DRAIN_INIT = DW'(DUT_LAT > 0 ? DUT_LAT - 1 : 0);

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [TT_W-1:0] exp_q, exp_d;
    logic [TT_W-1:0] tt_q, tt_d;
    logic [N_IN:0]   cnt_q, cnt_d;
    logic [N_IN-1:0] first_q, first_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            match_q, match_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic            sweeping;
    logic            cap_vld;
    logic [N_IN-1:0] cap_idx;

    assign sweeping = (state_q == DRIVE) || (state_q == DRAIN);

    tt_index_pipe #(
        .LAT (DUT_LAT),
        .IW  (N_IN)
    ) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (abort && sweeping),
        .in_vld  (state_q == DRIVE),
        .in_idx  (vec_q),
        .out_vld (cap_vld),
        .out_idx (cap_idx)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        exp_d   = exp_q;
        tt_d    = tt_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        drain_d = drain_q;
        match_d = match_q;
        done_d  = 1'b0;

        // Indices arrive in ascending order, so the first recorded miss is the lowest.
        if (cap_vld) begin
            tt_d[cap_idx] = dut_y;
            if (dut_y != exp_q[cap_idx]) begin
                if (cnt_q == '0) first_d = cap_idx;
                if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    exp_d   = expected;
                    vec_d   = '0;
                    tt_d    = '0;
                    cnt_d   = '0;
                    first_d = '0;
                    match_d = 1'b0;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (vec_q == VEC_MAX) begin
                    state_d = (DUT_LAT > 0) ? DRAIN : DONE;
                    drain_d = DRAIN_INIT;
                end else begin
                    vec_d = vec_q + 1'b1;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (drain_q == '0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                match_d = (cnt_q == '0);
            end
            default: state_d = IDLE;
        endcase

        // busy covers the DONE cycle so it drops exactly as done rises.
        busy_d = (state_d == DRIVE) || (state_d == DRAIN) || (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            cnt_q   <= '0;
            first_q <= '0;
            drain_q <= '0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            drain_q <= drain_d;
            match_q <= match_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign vec_out        = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign match          = match_q;
    assign tt_out         = tt_q;
    assign mismatch_cnt   = cnt_q;
    assign first_mismatch = first_q;

endmodule

// File: tb/tb_tt_capture_checker.sv
// Scoreboard bench: two checkers (combinational netlist and a 2-cycle registered
// netlist) swept with directed and random truth tables against a table-level model.
module tb_tt_capture_checker;

    localparam int N_IN = 6;
    localparam int TT_W = 64;
    localparam logic [63:0] F_AND = 64'hFFFF_0000_0000_0000;
    localparam logic [63:0] F_XOR = 64'h6666_6666_6666_6666;

    typedef struct packed {
        logic [63:0] tt;
        logic        match;
        logic [6:0]  cnt;
        logic [5:0]  first;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_s[2], abort_s[2], y_s[2], busy_s[2], done_s[2], match_s[2];
    logic [63:0] exp_in_s[2], tt_s[2], fn_s[2];
    logic [5:0]  vec_s[2], first_s[2];
    logic [6:0]  cnt_s[2];
    logic        y1, y2;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$], q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Bench-side netlists: a lookup of the chosen function, direct or registered twice.
    assign y_s[0] = fn_s[0][vec_s[0]];
    always @(posedge clk) begin
        y1 <= fn_s[1][vec_s[1]];
        y2 <= y1;
    end
    assign y_s[1] = y2;

    tt_capture_checker #(.N_IN(N_IN), .DUT_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
        .expected(exp_in_s[0]), .dut_y(y_s[0]), .vec_out(vec_s[0]), .busy(busy_s[0]),
        .done(done_s[0]), .match(match_s[0]), .tt_out(tt_s[0]),
        .mismatch_cnt(cnt_s[0]), .first_mismatch(first_s[0]));

    tt_capture_checker #(.N_IN(N_IN), .DUT_LAT(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
        .expected(exp_in_s[1]), .dut_y(y_s[1]), .vec_out(vec_s[1]), .busy(busy_s[1]),
        .done(done_s[1]), .match(match_s[1]), .tt_out(tt_s[1]),
        .mismatch_cnt(cnt_s[1]), .first_mismatch(first_s[1]));

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", nm, d, act, want, cyc);
        end
    endtask

    function automatic exp_t model(input logic [63:0] f, input logic [63:0] ev, input int dcyc);
        exp_t        e;
        logic [63:0] diff;
        diff       = f ^ ev;
        e.tt       = f;
        e.match    = (diff == 64'd0);
        e.cnt      = '0;
        e.first    = '0;
        e.done_cyc = dcyc;
        for (int i = TT_W - 1; i >= 0; i--) begin
            if (diff[i]) begin
                e.cnt   = e.cnt + 7'd1;
                e.first = 6'(i);
            end
        end
        return e;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic chk_result(input int d, input exp_t e);
        chk("done_time", d, 64'(cyc), 64'(e.done_cyc));
        chk("tt_out", d, tt_s[d], e.tt);
        chk("match", d, 64'(match_s[d]), 64'(e.match));
        chk("mismatch_cnt", d, 64'(cnt_s[d]), 64'(e.cnt));
        chk("first_mismatch", d, 64'(first_s[d]), 64'(e.first));
    endtask

    // Monitor: every done pulse must correspond to a queued sweep.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rst_n && done_s[d]) begin
                if (qsize(d) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done dut%0d: got done=1 expected no pulse (cycle %0d)", d, cyc);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk_result(d, e);
                end
            end
        end
    end

    task automatic chk_zero(input int d);
        chk("rst_vec_out", d, 64'(vec_s[d]), 64'd0);
        chk("rst_busy", d, 64'(busy_s[d]), 64'd0);
        chk("rst_done", d, 64'(done_s[d]), 64'd0);
        chk("rst_match", d, 64'(match_s[d]), 64'd0);
        chk("rst_tt_out", d, tt_s[d], 64'd0);
        chk("rst_mismatch_cnt", d, 64'(cnt_s[d]), 64'd0);
        chk("rst_first_mismatch", d, 64'(first_s[d]), 64'd0);
    endtask

    // One sweep on checker d. ab_at/st_at/rs_at < 0 disable abort, busy-start, reset.
    task automatic run(input int d, input logic [63:0] f, input logic [63:0] ev,
                       input int ab_at, input int st_at, input int rs_at, input bit ab0);
        int          lat, e0, t;
        exp_t        e;
        logic [63:0] lo, hi;
        lat = (d == 0) ? 0 : 2;
        @(negedge clk);
        fn_s[d]     = f;
        exp_in_s[d] = ev;
        start_s[d]  = 1'b1;
        abort_s[d]  = ab0;
        e0 = cyc + 1;
        e  = model(f, ev, e0 + TT_W + lat + 1);
        if (ab_at < 0 && rs_at < 0) begin
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clk);
        start_s[d] = 1'b0;
        abort_s[d] = 1'b0;
        for (int k = 0; k < TT_W; k++) begin
            chk("vec_out", d, 64'(vec_s[d]), 64'(k));
            chk("busy_drive", d, 64'(busy_s[d]), 64'd1);
            if (k == rs_at) begin
                #2 rst_n = 1'b0;
                #1 chk_zero(d);
                if (d == 0) q0.delete();
                else        q1.delete();
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (k == ab_at) begin
                abort_s[d] = 1'b1;
                @(negedge clk);
                abort_s[d] = 1'b0;
                chk("abort_busy", d, 64'(busy_s[d]), 64'd0);
                chk("abort_match", d, 64'(match_s[d]), 64'd0);
                @(negedge clk);
                lo = (64'd1 << (k - lat)) - 64'd1;
                hi = ~((64'd1 << (k + 1)) - 64'd1);
                chk("abort_tt_low", d, tt_s[d] & lo, f & lo);
                chk("abort_tt_high", d, tt_s[d] & hi, 64'd0);
                chk("abort_vec_hold", d, 64'(vec_s[d]), 64'(k));
                return;
            end
            start_s[d] = (k == st_at);
            @(negedge clk);
        end
        start_s[d] = 1'b0;
        for (int j = 0; j < lat; j++) begin
            chk("drain_vec_hold", d, 64'(vec_s[d]), 64'd63);
            chk("drain_busy", d, 64'(busy_s[d]), 64'd1);
            @(negedge clk);
        end
        chk("done_cycle_busy", d, 64'(busy_s[d]), 64'd1);
        t = 0;
        while (qsize(d) > 0 && t < 8) begin
            @(negedge clk);
            t++;
        end
        if (qsize(d) > 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout dut%0d: got no done expected done by cycle %0d", d, e.done_cyc);
            if (d == 0) q0.delete();
            else        q1.delete();
        end
        @(negedge clk);
        chk("match_stable", d, 64'(match_s[d]), 64'(e.match));
        chk("cnt_stable", d, 64'(cnt_s[d]), 64'(e.cnt));
        chk("idle_busy", d, 64'(busy_s[d]), 64'd0);
    endtask

    initial begin
        logic [63:0] f, ev;
        int          d, mode, ab;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i]  = 1'b0;
            abort_s[i]  = 1'b0;
            exp_in_s[i] = '0;
            fn_s[i]     = '0;
        end
        y1 = 1'b0;
        y2 = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero(0);
        chk_zero(1);
        rst_n = 1'b1;

        run(0, F_AND, F_AND, -1, -1, -1, 1'b0);
        run(0, F_AND, 64'h7FFF_0000_0000_0001, -1, -1, -1, 1'b0);
        run(1, F_XOR, F_XOR, -1, -1, -1, 1'b0);
        run(0, F_AND, F_AND, 10, -1, -1, 1'b0);
        run(0, F_AND, F_AND, -1, -1, -1, 1'b0);
        run(0, F_AND, F_XOR, -1, 30, -1, 1'b0);
        run(0, F_AND, F_AND, -1, -1, 40, 1'b0);
        run(0, F_AND, F_AND, -1, -1, -1, 1'b0);
        run(1, F_XOR, F_XOR, -1, -1, -1, 1'b1);
        run(1, F_XOR, F_AND, 20, -1, -1, 1'b0);

        for (int it = 0; it < 12; it++) begin
            d    = int'($urandom_range(0, 1));
            f    = {$urandom, $urandom};
            mode = int'($urandom_range(0, 3));
            case (mode)
                0:       ev = f;
                1:       ev = f ^ (64'd1 << $urandom_range(0, 63));
                2:       ev = ~f;
                default: ev = {$urandom, $urandom};
            endcase
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(3, 60)) : -1;
            run(d, f, ev, ab, -1, -1, 1'b0);
        end

        repeat (4) @(negedge clk);
        chk("queue0_drained", 0, 64'(q0.size()), 64'd0);
        chk("queue1_drained", 1, 64'(q1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
